sha256_msg_feeder: RTL and testbench
====================================

# sha256_msg_feeder

Upstream front end for `sha256_core`. Accepts a message as a stream of 32-bit big-endian words and applies SHA-256 padding: a 0x80 byte, zero fill, and a 64-bit bit length. Builds each 512-bit block, launches the core with `input_valid`, and chains `Hash_out` back into `Hash_in` between blocks. Returns the final 256-bit digest through a valid/ready handshake.

## Interface
- No parameters. The IV is fixed at 6A09E667 BB67AE85 3C6EF372 A54FF53A 510E527F 9B05688C 1F83D9AB 5BE0CD19.
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 32: message word. Byte 0 is bits [31:24].
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: marks the final word of the message.
- `in_bytes` in 2: number of valid bytes in the last word, with 0 meaning 4. Ignored unless `in_last` is high.
- `in_ready` out 1: the block accepts a word this cycle.
- `core_data` out 512: drives the core's `data_in`. Word 0 is bits [511:480].
- `core_hash_in` out 256: drives the core's `Hash_in` (the chaining value).
- `core_start` out 1: drives the core's `input_valid`. Single-cycle pulse.
- `core_hash_out` in 256: from the core's `Hash_out`.
- `core_done` in 1: from the core's `output_valid`.
- `digest` out 256: final hash.
- `digest_valid` out 1: `digest` holds a valid result.
- `digest_ready` in 1: consumer takes `digest`.
- `busy` out 1: a message is in progress.

## Operation
- States:
  - FILL: idle, or accepting words.
  - PAD: one cycle that completes padding.
  - START: one cycle with `core_start`=1.
  - WAIT: core running.
  - DONE: digest presented.
- FILL:
  - `in_ready`=1. Each handshake (`in_valid`&`in_ready`) writes word index `wi` of the block buffer, increments `wi` (range 0..15), and adds 32 to `len_bits` (64-bit, modulo 2^64).
  - On the last word, only `in_bytes` bytes are counted: `len_bits` increases by 8×n, where n=4 when `in_bytes`=0.
  - Unused low bytes of the last word are zeroed.
- 16th word accepted without `in_last` → START with `final`=0.
- Word accepted with `in_last` → PAD. Let p = number of used bytes in the current block (1..64).
  - p<64: write 0x80 at byte p and zero bytes p+1..63.
  - p≤55 additionally: write `len_bits` into words 14–15, set `final`=1, then go to START.
  - p in 56..63, or p=64: set `final`=0 and `tail`=1, then go to START. When p=64 the 0x80 byte is deferred to the tail block (`tail80`=1).
- START: assert `core_start` for one cycle, then go to WAIT. `core_data` and `core_hash_in` stay stable until the core finishes.
- WAIT:
  - `core_done` is sampled only in this state.
  - On `core_done`: chain ← `core_hash_out` and `wi` ← 0.
  - Next state:
    - `final` → DONE, with `digest` ← `core_hash_out`.
    - `tail` → build the tail block, then START with `final`=1. Tail block: word0 = 0x80000000 if `tail80` else 0; words 1–13 = 0; words 14–15 = `len_bits`.
    - otherwise → FILL.
- DONE:
  - `digest_valid`=1 and `digest` is held stable while `digest_ready`=0.
  - On handshake: go to FILL, chain ← IV, `len_bits` ← 0, clear flags.
- `busy` = (state≠FILL) | (`wi`≠0).
- Zero-length messages are not supported. Every message has at least one word with `in_last` set.

## Timing
- Reset values:
  - state FILL, so `in_ready`=1 from the first cycle after `rst`.
  - `core_start`=0, `digest_valid`=0, `digest`=0, `core_data`=0, `core_hash_in`=IV, `busy`=0, `len_bits`=0.
- `rst` in any state (including mid-WAIT) aborts the message:
  - All state returns to reset values.
  - A running core is ignored. Its `core_done` is not sampled until the next WAIT.
- Core latency: `core_start` at cycle T → `core_done` at T+65.
  - The feeder captures `core_hash_out` at the T+65 edge.
  - A stale `core_done`=1 during START must be ignored.
- Per-block cost with back-to-back input: 16 FILL + 1 START + 65 WAIT cycles. A last block adds 1 PAD cycle. The tail block adds 66 cycles.
- `in_valid` while `in_ready`=0 is ignored. `in_data` is not consumed.

## Configuration
- `SHA256_FEEDER_BLKCNT_EN` defined:
  - Adds output `block_count` (32 bits, reset 0), which increments on every `core_start`, wraps at 2^32, and is not cleared by the DONE handshake.
- `SHA256_FEEDER_BLKCNT_EN` undefined:
  - The port and counter do not exist. Behaviour is otherwise identical.

## Test plan
- "abc": one word 0x61626300 with `in_last`=1, `in_bytes`=3.
  - `core_data` = 0x61626380, 0…, word15 = 0x00000018.
  - `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 56-byte "abcdbcdecdefdefg…nopq" (14 words, last with `in_bytes`=0):
  - Two `core_start` pulses. The second block is all zero except word15 = 0x000001C0.
  - `digest` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64-byte message (16 full words):
  - First block carries no padding.
  - Tail block word0 = 0x80000000, word15 = 0x00000200.
  - Second block's `core_hash_in` equals the first block's `core_hash_out`.
- Backpressure: hold `digest_ready`=0 for 10 cycles after `digest_valid`.
  - `digest` is stable and `in_ready`=0 throughout.
  - Handshake → `in_ready`=1 the next cycle, and `core_hash_in`=IV.
- `rst` pulsed 20 cycles into WAIT, then "abc" sent:
  - No `digest_valid` from the aborted message.
  - "abc" digest is correct.
- Random `in_valid` gaps on the 56-byte message → same digest as gap-free input.

Source files
------------

// File: rtl/sha256_msg_feeder_if.sv
// Bus bundle between sha256_msg_feeder and its environment (message source, sha256_core, digest sink).
// With SHA256_FEEDER_BLKCNT_EN defined the bundle also carries block_count.
interface sha256_msg_feeder_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         in_ready;
    logic [511:0] core_data;
    logic [255:0] core_hash_in;
    logic         core_start;
    logic [255:0] core_hash_out;
    logic         core_done;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;
    logic [2:0]   dbg_state;
`ifdef SHA256_FEEDER_BLKCNT_EN
    logic [31:0]  block_count;
`endif

    // Handshakes: a word moves when in_valid & in_ready at a rising edge; the digest
    // moves when digest_valid & digest_ready at a rising edge. Valid never depends on ready.
    modport slave (
        input  in_data, in_valid, in_last, in_bytes, core_hash_out, core_done, digest_ready,
        output in_ready, core_data, core_hash_in, core_start, digest, digest_valid, busy,
`ifdef SHA256_FEEDER_BLKCNT_EN
        output block_count,
`endif
        output dbg_state
    );

    modport master (
        output in_data, in_valid, in_last, in_bytes, core_hash_out, core_done, digest_ready,
        input  in_ready, core_data, core_hash_in, core_start, digest, digest_valid, busy,
`ifdef SHA256_FEEDER_BLKCNT_EN
        input  block_count,
`endif
        input  dbg_state
    );
endinterface

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message padder and block sequencer in front of sha256_core.
// Optional SHA256_FEEDER_BLKCNT_EN adds a free-running block_count of core launches.
module sha256_msg_feeder (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_feeder_if.slave    bus
);
    localparam logic [255:0] IV = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;

    typedef enum logic [2:0] {S_FILL, S_PAD, S_START, S_WAIT, S_DONE} state_t;

    state_t         state_q;
    logic [3:0]     wi_q;
    logic [63:0]    len_q;
    logic [511:0]   data_q;
    logic [255:0]   chain_q;
    logic [255:0]   digest_q;
    logic           digest_valid_q;
    logic           core_start_q;
    logic           final_q;
    logic           tail_q;
    logic           tail80_q;
    logic [6:0]     pbytes_q;
`ifdef SHA256_FEEDER_BLKCNT_EN
    logic [31:0]    block_count_q;
`endif

    logic [2:0]     nbytes_d;
    logic [31:0]    in_word_d;
    logic [511:0]   blk_pad_d;
    logic [511:0]   blk_tail_d;

    assign nbytes_d = (bus.in_last && bus.in_bytes != 2'd0) ? {1'b0, bus.in_bytes} : 3'd4;

    always_comb begin
        in_word_d = bus.in_data;
        case (nbytes_d)
            3'd1:    in_word_d[23:0] = 24'h0;
            3'd2:    in_word_d[15:0] = 16'h0;
            3'd3:    in_word_d[7:0]  = 8'h0;
            default: ;
        endcase
    end

    // 0x80 marker at byte p, zeros after it; length only fits when p <= 55.
    always_comb begin
        blk_pad_d = data_q;
        for (int b = 0; b < 64; b++) begin
            if (7'(b) == pbytes_q)
                blk_pad_d[511 - 8*b -: 8] = 8'h80;
            else if (7'(b) > pbytes_q)
                blk_pad_d[511 - 8*b -: 8] = 8'h00;
        end
        if (pbytes_q <= 7'd55)
            blk_pad_d[63:0] = len_q;
    end

    assign blk_tail_d = {(tail80_q ? 32'h8000_0000 : 32'h0), 416'h0, len_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FILL;
            wi_q           <= 4'd0;
            len_q          <= 64'd0;
            data_q         <= '0;
            chain_q        <= IV;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            core_start_q   <= 1'b0;
            final_q        <= 1'b0;
            tail_q         <= 1'b0;
            tail80_q       <= 1'b0;
            pbytes_q       <= 7'd0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (bus.in_valid) begin
                        data_q[{~wi_q, 5'b0} +: 32] <= in_word_d;
                        wi_q  <= wi_q + 4'd1;
                        len_q <= len_q + {58'd0, nbytes_d, 3'd0};
                        if (bus.in_last) begin
                            pbytes_q <= {1'b0, wi_q, 2'b00} + {4'b0, nbytes_d};
                            state_q  <= S_PAD;
                        end else if (wi_q == 4'd15) begin
                            final_q      <= 1'b0;
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end
                    end
                end
                S_PAD: begin
                    data_q       <= blk_pad_d;
                    final_q      <= (pbytes_q <= 7'd55);
                    tail_q       <= (pbytes_q > 7'd55);
                    tail80_q     <= (pbytes_q == 7'd64);
                    core_start_q <= 1'b1;
                    state_q      <= S_START;
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.core_done) begin
                        chain_q <= bus.core_hash_out;
                        wi_q    <= 4'd0;
                        if (final_q) begin
                            digest_q       <= bus.core_hash_out;
                            digest_valid_q <= 1'b1;
                            state_q        <= S_DONE;
                        end else if (tail_q) begin
                            data_q       <= blk_tail_d;
                            final_q      <= 1'b1;
                            tail_q       <= 1'b0;
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.digest_ready) begin
                        digest_valid_q <= 1'b0;
                        chain_q        <= IV;
                        len_q          <= 64'd0;
                        final_q        <= 1'b0;
                        tail_q         <= 1'b0;
                        tail80_q       <= 1'b0;
                        state_q        <= S_FILL;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

`ifdef SHA256_FEEDER_BLKCNT_EN
    // Survives the digest handshake; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst)
            block_count_q <= 32'd0;
        else if (core_start_q)
            block_count_q <= block_count_q + 32'd1;
    end
    assign bus.block_count = block_count_q;
`endif

    assign bus.in_ready     = (state_q == S_FILL);
    assign bus.busy         = (state_q != S_FILL) || (wi_q != 4'd0);
    assign bus.core_data    = data_q;
    assign bus.core_hash_in = chain_q;
    assign bus.core_start   = core_start_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Directed bench for sha256_msg_feeder with a behavioural sha256_core (65-cycle latency).
module tb_sha256_msg_feeder;
    localparam logic [255:0] IV = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] M56_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_feeder_if bus();
    sha256_msg_feeder dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] msg [0:15];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Core model: done pulses in cycle T+65 for a start in cycle T; a new start restarts it.
    int           m_cnt = 0;
    logic         m_done = 1'b0;
    logic [255:0] m_hout = '0;
    logic [255:0] m_pend = '0;
    logic [511:0] blk_log [$];
    logic [255:0] hin_log [$];
    assign bus.core_done     = m_done;
    assign bus.core_hash_out = m_hout;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (bus.core_start) begin
            m_cnt  <= 1;
            m_pend <= sha_blk(bus.core_hash_in, bus.core_data);
            blk_log.push_back(bus.core_data);
            hin_log.push_back(bus.core_hash_in);
        end else if (m_cnt == 64) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
            m_hout <= m_pend;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic send_msg(input int n, input logic [1:0] lastb, input bit gaps);
        int guard;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            bus.in_data  = msg[i];
            bus.in_last  = (i == n - 1);
            bus.in_bytes = (i == n - 1) ? lastb : 2'd0;
            bus.in_valid = 1'b1;
            guard = 0;
            while (!bus.in_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 500) begin
                vectors++; miscompares++;
                $display("FAIL in_ready_timeout word %0d got in_ready=0 want 1", i);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_digest(output logic [255:0] d);
        int guard = 0;
        while (!bus.digest_valid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            vectors++; miscompares++;
            $display("FAIL digest_timeout got digest_valid=0 want 1");
        end
        d = bus.digest;
    endtask

    task automatic take_digest();
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.core_start !== 1'b0) begin miscompares++; $display("FAIL rst_core_start got %b want 0", bus.core_start); end
        vectors++; if (bus.digest_valid !== 1'b0) begin miscompares++; $display("FAIL rst_digest_valid got %b want 0", bus.digest_valid); end
        vectors++; if (bus.digest !== 256'h0) begin miscompares++; $display("FAIL rst_digest got %h want 0", bus.digest); end
        vectors++; if (bus.core_data !== 512'h0) begin miscompares++; $display("FAIL rst_core_data got %h want 0", bus.core_data); end
        vectors++; if (bus.core_hash_in !== IV) begin miscompares++; $display("FAIL rst_hash_in got %h want %h", bus.core_hash_in, IV); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        vectors++; if (bus.dbg_state !== 3'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", bus.dbg_state); end
`ifdef SHA256_FEEDER_BLKCNT_EN
        vectors++; if (bus.block_count !== 32'd0) begin miscompares++; $display("FAIL rst_block_count got %0d want 0", bus.block_count); end
`endif
    endtask

    task automatic test_abc();
        logic [255:0] d;
        logic [511:0] exp_blk;
        exp_blk = {32'h61626380, 448'h0, 32'h00000018};
        blk_log.delete(); hin_log.delete();
        msg[0] = 32'h61626300;
        send_msg(1, 2'd3, 1'b0);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abc_busy got %b want 1", bus.busy); end
        wait_digest(d);
        vectors++; if (blk_log.size() != 1) begin miscompares++; $display("FAIL abc_starts got %0d want 1", blk_log.size()); end
        vectors++; if (blk_log.size() < 1 || blk_log[0] !== exp_blk) begin miscompares++; $display("FAIL abc_block got %h want %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, exp_blk); end
        vectors++; if (hin_log.size() < 1 || hin_log[0] !== IV) begin miscompares++; $display("FAIL abc_hash_in got %h want %h", (hin_log.size() > 0) ? hin_log[0] : 256'h0, IV); end
        vectors++; if (d !== ABC_DIG) begin miscompares++; $display("FAIL abc_digest got %h want %h", d, ABC_DIG); end
        take_digest();
    endtask

    task automatic load_56();
        logic [31:0] w56 [0:13];
        w56 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
                32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        for (int i = 0; i < 14; i++) msg[i] = w56[i];
    endtask

    task automatic test_msg56();
        logic [255:0] d;
        logic [511:0] exp0, exp1;
        load_56();
        exp0 = '0;
        for (int i = 0; i < 14; i++) exp0[511 - 32*i -: 32] = msg[i];
        exp0[63:32] = 32'h80000000;
        exp1 = {480'h0, 32'h000001C0};
        blk_log.delete(); hin_log.delete();
        send_msg(14, 2'd0, 1'b0);
        wait_digest(d);
        vectors++; if (blk_log.size() != 2) begin miscompares++; $display("FAIL m56_starts got %0d want 2", blk_log.size()); end
        vectors++; if (blk_log.size() < 2 || blk_log[0] !== exp0) begin miscompares++; $display("FAIL m56_block0 got %h want %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, exp0); end
        vectors++; if (blk_log.size() < 2 || blk_log[1] !== exp1) begin miscompares++; $display("FAIL m56_block1 got %h want %h", (blk_log.size() > 1) ? blk_log[1] : 512'h0, exp1); end
        vectors++; if (d !== M56_DIG) begin miscompares++; $display("FAIL m56_digest got %h want %h", d, M56_DIG); end
        take_digest();
    endtask

    task automatic test_msg64();
        logic [255:0] d, h0, exp_d;
        logic [511:0] exp0, exp1;
`ifdef SHA256_FEEDER_BLKCNT_EN
        logic [31:0] bc0;
        bc0 = bus.block_count;
`endif
        for (int i = 0; i < 16; i++) msg[i] = 32'h30313233 + 32'h04040404 * i;
        exp0 = '0;
        for (int i = 0; i < 16; i++) exp0[511 - 32*i -: 32] = msg[i];
        exp1 = {32'h80000000, 448'h0, 32'h00000200};
        h0 = sha_blk(IV, exp0);
        exp_d = sha_blk(h0, exp1);
        blk_log.delete(); hin_log.delete();
        send_msg(16, 2'd0, 1'b0);
        wait_digest(d);
        vectors++; if (blk_log.size() != 2) begin miscompares++; $display("FAIL m64_starts got %0d want 2", blk_log.size()); end
        vectors++; if (blk_log.size() < 2 || blk_log[0] !== exp0) begin miscompares++; $display("FAIL m64_block0 got %h want %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, exp0); end
        vectors++; if (blk_log.size() < 2 || blk_log[1] !== exp1) begin miscompares++; $display("FAIL m64_tail got %h want %h", (blk_log.size() > 1) ? blk_log[1] : 512'h0, exp1); end
        vectors++; if (hin_log.size() < 2 || hin_log[1] !== h0) begin miscompares++; $display("FAIL m64_chain got %h want %h", (hin_log.size() > 1) ? hin_log[1] : 256'h0, h0); end
        vectors++; if (d !== exp_d) begin miscompares++; $display("FAIL m64_digest got %h want %h", d, exp_d); end
`ifdef SHA256_FEEDER_BLKCNT_EN
        vectors++; if (bus.block_count - bc0 !== 32'd2) begin miscompares++; $display("FAIL m64_block_count got %0d want 2", bus.block_count - bc0); end
`endif
        take_digest();
    endtask

    task automatic test_boundary();
        logic [255:0] d;
        logic [511:0] exp0, exp1;
        for (int i = 0; i < 16; i++) msg[i] = 32'hA1B2C3D4 ^ (32'h01010101 * i);
        // p = 55: marker lands in the last byte of word 13, length fits.
        exp0 = '0;
        for (int i = 0; i < 13; i++) exp0[511 - 32*i -: 32] = msg[i];
        exp0[95:64] = {msg[13][31:8], 8'h80};
        exp0[31:0]  = 32'h000001B8;
        blk_log.delete(); hin_log.delete();
        send_msg(14, 2'd3, 1'b0);
        wait_digest(d);
        vectors++; if (blk_log.size() != 1 || blk_log[0] !== exp0) begin miscompares++; $display("FAIL p55_block got %h want %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, exp0); end
        vectors++; if (d !== sha_blk(IV, exp0)) begin miscompares++; $display("FAIL p55_digest got %h want %h", d, sha_blk(IV, exp0)); end
        take_digest();
        // p = 60: marker in word 15, length spills into a tail block.
        exp0 = '0;
        for (int i = 0; i < 15; i++) exp0[511 - 32*i -: 32] = msg[i];
        exp0[31:0] = 32'h80000000;
        exp1 = {480'h0, 32'h000001E0};
        blk_log.delete(); hin_log.delete();
        send_msg(15, 2'd0, 1'b0);
        wait_digest(d);
        vectors++; if (blk_log.size() != 2 || blk_log[0] !== exp0) begin miscompares++; $display("FAIL p60_block0 got %h want %h", (blk_log.size() > 0) ? blk_log[0] : 512'h0, exp0); end
        vectors++; if (blk_log.size() != 2 || blk_log[1] !== exp1) begin miscompares++; $display("FAIL p60_tail got %h want %h", (blk_log.size() > 1) ? blk_log[1] : 512'h0, exp1); end
        vectors++; if (d !== sha_blk(sha_blk(IV, exp0), exp1)) begin miscompares++; $display("FAIL p60_digest got %h want %h", d, sha_blk(sha_blk(IV, exp0), exp1)); end
        take_digest();
    endtask

    task automatic test_backpressure();
        logic [255:0] d;
        msg[0] = 32'h61626300;
        send_msg(1, 2'd3, 1'b0);
        wait_digest(d);
        bus.in_data  = 32'hDEADBEEF;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++; if (bus.digest !== ABC_DIG || bus.digest_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_digest cycle %0d got %h v=%b want %h v=1", c, bus.digest, bus.digest_valid, ABC_DIG); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, bus.in_ready); end
        end
        bus.digest_ready = 1'b1;
        bus.in_valid     = 1'b0;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.core_hash_in !== IV) begin miscompares++; $display("FAIL bp_release_hash_in got %h want %h", bus.core_hash_in, IV); end
        vectors++; if (bus.busy !== 1'b0 || bus.digest_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_idle got busy=%b v=%b want 0 0", bus.busy, bus.digest_valid); end
    endtask

    task automatic test_reset_abort();
        logic [255:0] d;
        int guard = 0;
        bit seen_valid = 1'b0;
        blk_log.delete(); hin_log.delete();
        msg[0] = 32'h61626300;
        send_msg(1, 2'd3, 1'b0);
        while (blk_log.size() == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vectors++; if (blk_log.size() == 0) begin miscompares++; $display("FAIL abort_no_start got 0 starts want 1"); end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got rdy=%b busy=%b want 1 0", bus.in_ready, bus.busy); end
        vectors++; if (bus.core_hash_in !== IV) begin miscompares++; $display("FAIL abort_hash_in got %h want %h", bus.core_hash_in, IV); end
        for (int c = 0; c < 70; c++) begin
            if (bus.digest_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        vectors++; if (seen_valid) begin miscompares++; $display("FAIL abort_stale_digest got digest_valid=1 want 0"); end
        send_msg(1, 2'd3, 1'b0);
        wait_digest(d);
        vectors++; if (d !== ABC_DIG) begin miscompares++; $display("FAIL abort_abc_digest got %h want %h", d, ABC_DIG); end
        take_digest();
    endtask

    task automatic test_gaps();
        logic [255:0] d;
        load_56();
        send_msg(14, 2'd0, 1'b1);
        wait_digest(d);
        vectors++; if (d !== M56_DIG) begin miscompares++; $display("FAIL gaps_digest got %h want %h", d, M56_DIG); end
        take_digest();
    endtask

    initial begin
        bus.in_data      = 32'h0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.in_bytes     = 2'd0;
        bus.digest_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_abc();
        test_msg56();
        test_msg64();
        test_boundary();
        test_backpressure();
        test_reset_abort();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
